keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Drives the column lines of a 4x4 matrix keypad one at a time, samples the row lines through a synchronizer, and reports the first key found as a 4-bit hex code with a level `key_pressed` flag. Sits between the keypad pins and the downstream debounce stage, which consumes `key_code`/`key_pressed`. It does no bounce filtering: it locks onto a key, holds its column driven while that key stays down, and resumes scanning on release.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each column is driven before rows are sampled; must be >= 3 to cover synchronizer latency.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rows`  in  4  keypad row inputs, active-low, externally pulled up, asynchronous.
- `cols`  out  4  column drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  hex code of the held or most recent key.
- `key_pressed`  out  1  high while the locked key is held.

## Operation
- Rows pass through a 2-flop synchronizer (`rows_s`). All decisions use `rows_s` only.
- State `SCAN`:
  - `cols = ~(4'b1 << col_idx)`.
  - `settle_cnt` counts 0..SETTLE_CYCLES-1.
  - At `settle_cnt == SETTLE_CYCLES-1` (sample cycle):
    - If any `rows_s` bit is low, the lowest-index low row is `row_idx`, `key_code <= KEYMAP[row_idx][col_idx]`, `key_pressed <= 1`, next state is `HOLD`.
    - Otherwise `col_idx` advances by 1 (3 wraps to 0), `settle_cnt <= 0`.
- State `HOLD`:
  - `col_idx` is frozen and `cols` is unchanged.
  - Every cycle, test `rows_s[row_idx]`.
  - When it is high: `key_pressed <= 0`, `col_idx <= col_idx+1` (wrapping), `settle_cnt <= 0`, next state is `SCAN`.
  - `key_code` keeps its last value.
- Key map, row-major with row r and column c:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- Multiple keys:
  - Same column at sample: lowest row wins.
  - During `HOLD`: all other keys are ignored, including other rows of the same column.
- Reset values: state `SCAN`, `col_idx = 0`, `cols = 4'b1110`, `settle_cnt = 0`, `key_pressed = 0`, `key_code = 4'hF`, synchronizer flops `4'b1111`.
- Reset asserted mid-`HOLD` or mid-settle returns to the reset values on the next edge, with no partial output.
- Illegal state encoding goes to `SCAN` via the default arm.

## Timing
- All outputs are registered. `cols` changes only on a column advance, which is the same edge that zeroes `settle_cnt`.
- Idle scan period is 4 × SETTLE_CYCLES cycles, with each column held exactly SETTLE_CYCLES cycles.
- Press detection: `key_pressed`/`key_code` update on the sample edge of the first visit to that column after `rows_s` shows low. Worst case is 4 × SETTLE_CYCLES + 2 cycles from pin assertion.
- Release: `key_pressed` falls 3 edges after the row pin returns high (2 synchronizer edges + 1 register edge). `cols` advances on that same edge.
- A row pulse that is not low in `rows_s` on a sample cycle is not detected.

## Structure
- Package `keypad_pkg`:
  - `NUM_ROWS`/`NUM_COLS` = 4.
  - `scan_state_t` enum {`SCAN`, `HOLD`}.
  - `KEYMAP` constant, 4×4 of logic[3:0].
- Sub-module `sync_2ff`, parameterized by `WIDTH` and `RESET_VAL`, used for `rows`.
- Settle counter width is `$clog2(SETTLE_CYCLES)`.

## Test plan
The bench keypad model drives `rows[r] = 0` iff key (r,c) is pressed and `cols[c] == 0`. SETTLE_CYCLES = 4.
1. Reset, no keys: `cols` = 1110, `key_pressed` = 0, `key_code` = F. Then `cols` steps 1110→1101→1011→0111→1110, 4 cycles each.
2. Press key '5' (r1,c1): on the column-1 sample edge, `key_pressed` = 1 and `key_code` = 5. `cols` stays 1101 for a 50-cycle hold.
3. Release '5': `key_pressed` = 0 exactly 3 edges after the row pin returns high. `cols` = 1011 on that edge and `key_code` stays 5.
4. Press '1' and '4' together (same column): `key_code` = 1. While holding '1', press '2' (c1): no change until '1' is released. Then '2' is detected with `key_code` = 2.
5. Corner keys:
   - '#' (r3,c2) gives `key_code` = F.
   - '0' (r3,c1) gives 0.
   - 'D' (r3,c3) gives D, followed by a wrap to `cols` = 1110 after release.
   - A 1-cycle row pulse outside the sample cycle is not reported.
6. Reset asserted during `HOLD` of key '9': on the next edge `key_pressed` = 0, `key_code` = F, `cols` = 1110. Scanning then resumes and re-detects the still-pressed '9' on column 2.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic {
      SCAN = 1'b0,
      HOLD = 1'b1
   } scan_state_t;

   // Row-major: KEYMAP[row][col]
   localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to RESET_VAL.
module sync_2ff #(
   parameter int                WIDTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= RESET_VAL;
         sync_p1 <= RESET_VAL;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one column low at a time, locks onto the
// first key found and holds that column until the key is released.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_pressed
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [3:0]       rows_s;
   scan_state_t      state, state_nxt;
   logic [1:0]       col_idx, col_idx_nxt;
   logic [1:0]       row_idx, row_idx_nxt;
   logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
   logic [3:0]       cols_nxt;
   logic [3:0]       key_code_nxt;
   logic             key_pressed_nxt;
   logic             hit;
   logic [1:0]       hit_row;

   sync_2ff #(
      .WIDTH     (NUM_ROWS),
      .RESET_VAL (4'b1111)
   ) u_rows_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_s)
   );

   // Lowest-index active (low) row wins when several share the column.
   always_comb begin
      hit     = 1'b0;
      hit_row = 2'd0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!rows_s[r]) begin
            hit     = 1'b1;
            hit_row = 2'(r);
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      col_idx_nxt     = col_idx;
      row_idx_nxt     = row_idx;
      settle_cnt_nxt  = settle_cnt;
      key_code_nxt    = key_code;
      key_pressed_nxt = key_pressed;
      case (state)
         SCAN: begin
            if (settle_cnt == CNT_LAST) begin
               if (hit) begin
                  state_nxt       = HOLD;
                  row_idx_nxt     = hit_row;
                  key_code_nxt    = KEYMAP[hit_row][col_idx];
                  key_pressed_nxt = 1'b1;
               end else begin
                  col_idx_nxt    = col_idx + 2'd1;
                  settle_cnt_nxt = '0;
               end
            end else begin
               settle_cnt_nxt = settle_cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            // Only the locked row matters; every other key is ignored here.
            if (rows_s[row_idx]) begin
               state_nxt       = SCAN;
               key_pressed_nxt = 1'b0;
               col_idx_nxt     = col_idx + 2'd1;
               settle_cnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt       = SCAN;
            settle_cnt_nxt  = '0;
            key_pressed_nxt = 1'b0;
         end
      endcase
      cols_nxt = ~(4'b0001 << col_idx_nxt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         settle_cnt  <= '0;
         cols        <= 4'b1110;
         key_code    <= 4'hF;
         key_pressed <= 1'b0;
      end else begin
         state       <= state_nxt;
         col_idx     <= col_idx_nxt;
         row_idx     <= row_idx_nxt;
         settle_cnt  <= settle_cnt_nxt;
         cols        <= cols_nxt;
         key_code    <= key_code_nxt;
         key_pressed <= key_pressed_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad pin model, behavioural reference and directed/random stimulus.
module tb_keypad_scanner;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_pressed;

   logic [15:0] keys  = '0;   // bit r*4+c set = key (r,c) held down
   logic [3:0]  pulse = '0;   // forces row pins low regardless of columns

   int n_checks = 0;
   int n_err    = 0;

   keypad_scanner #(.SETTLE_CYCLES(SC)) dut (
      .clk         (clk),
      .reset       (reset),
      .rows        (rows),
      .cols        (cols),
      .key_code    (key_code),
      .key_pressed (key_pressed)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && cols[c] == 1'b0) rows[r] = 1'b0;
      rows = rows & ~pulse;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_cols(input int c);
      return ~(4'b0001 << c);
   endfunction

   // Reference: key value table and a cycle model driven by a 2-deep pin history.
   int unsigned km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};
   int         m_col = 0, m_tick = 0, m_lock = -1, m_found;
   logic [3:0] m_code = 4'hF;
   logic       m_pressed = 1'b0;
   logic [3:0] sh0 = 4'hF, sh1 = 4'hF, m_s;
   bit         model_on = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_col = 0; m_tick = 0; m_lock = -1;
         m_code = 4'hF; m_pressed = 1'b0;
         sh0 = 4'hF; sh1 = 4'hF;
      end else begin
         m_s = sh1;
         sh1 = sh0;
         sh0 = rows;
         if (m_lock < 0) begin
            if (m_tick == SC - 1) begin
               m_found = -1;
               for (int r = 3; r >= 0; r--) if (!m_s[r]) m_found = r;
               if (m_found >= 0) begin
                  m_lock    = m_found;
                  m_code    = 4'(km[m_found*4 + m_col]);
                  m_pressed = 1'b1;
               end else begin
                  m_col  = (m_col + 1) % 4;
                  m_tick = 0;
               end
            end else begin
               m_tick++;
            end
         end else if (m_s[m_lock]) begin
            m_pressed = 1'b0;
            m_col     = (m_col + 1) % 4;
            m_tick    = 0;
            m_lock    = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_cols", cols, exp_cols(m_col));
         check("model_kp", key_pressed, m_pressed);
         check("model_code", key_code, m_code);
      end
   end

   task automatic wait_kp(input logic lvl, input int lim, input string tag);
      int n = 0;
      while (key_pressed !== lvl && n < lim) begin
         @(negedge clk);
         n++;
      end
      check(tag, key_pressed, lvl);
   endtask

   task automatic press_check(input int b, input logic [3:0] code, input string tag);
      keys[b] = 1'b1;
      wait_kp(1'b1, 40, {tag, "_kp"});
      check({tag, "_code"}, key_code, code);
   endtask

   int         corner_bit  [3] = '{14, 13, 15};
   logic [3:0] corner_code [3] = '{4'hF, 4'h0, 4'hD};

   initial begin
      logic [3:0] pc;
      logic       seen;
      int         n;

      // 1: reset values and idle scan sequence
      reset = 1'b1;
      repeat (2) @(negedge clk);
      model_on = 1'b1;
      check("rst_cols", cols, 4'b1110);
      check("rst_kp", key_pressed, 1'b0);
      check("rst_code", key_code, 4'hF);
      reset = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         check("scan_cols", cols, exp_cols((j / 4) % 4));
      end

      // 2: press '5' and hold
      press_check(5, 4'h5, "p5");
      check("p5_cols", cols, 4'b1101);
      repeat (50) @(negedge clk);
      check("hold5_cols", cols, 4'b1101);
      check("hold5_kp", key_pressed, 1'b1);

      // 3: release '5', falls on the third edge
      keys[5] = 1'b0;
      @(negedge clk); check("rel5_e1", key_pressed, 1'b1);
      @(negedge clk); check("rel5_e2", key_pressed, 1'b1);
      @(negedge clk); check("rel5_e3", key_pressed, 1'b0);
      check("rel5_cols", cols, 4'b1011);
      check("rel5_code", key_code, 4'h5);

      // 4: '1' and '4' together, then '2' while '1' held
      keys[0] = 1'b1;
      keys[4] = 1'b1;
      wait_kp(1'b1, 40, "p14_kp");
      check("p14_code", key_code, 4'h1);
      keys[1] = 1'b1;
      repeat (20) @(negedge clk);
      check("p2held_code", key_code, 4'h1);
      check("p2held_cols", cols, 4'b1110);
      keys[0] = 1'b0;
      wait_kp(1'b0, 10, "r1_kp");
      wait_kp(1'b1, 40, "p2_kp");
      check("p2_code", key_code, 4'h2);
      keys = '0;
      wait_kp(1'b0, 10, "r2_kp");

      // 5: corner keys
      for (int i = 0; i < 3; i++) begin
         press_check(corner_bit[i], corner_code[i], "corner");
         keys[corner_bit[i]] = 1'b0;
         wait_kp(1'b0, 10, "corner_rel");
         if (corner_bit[i] == 15) check("d_wrap_cols", cols, 4'b1110);
      end

      // 5: one-cycle pulse just after a column change never reaches a sample
      pc = cols;
      n = 0;
      while (cols === pc && n < 20) begin
         @(negedge clk);
         n++;
      end
      pulse = 4'b0001;
      @(negedge clk);
      pulse = 4'b0000;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= key_pressed;
      end
      check("pulse_kp", seen, 1'b0);

      // 6: reset during HOLD of '9'
      press_check(10, 4'h9, "p9");
      reset = 1'b1;
      @(negedge clk);
      check("rst9_kp", key_pressed, 1'b0);
      check("rst9_code", key_code, 4'hF);
      check("rst9_cols", cols, 4'b1110);
      reset = 1'b0;
      wait_kp(1'b1, 40, "p9again_kp");
      check("p9again_code", key_code, 4'h9);
      check("p9again_cols", cols, 4'b1011);
      keys = '0;
      wait_kp(1'b0, 10, "r9_kp");

      // Random keys, pulses and occasional resets against the reference
      repeat (1500) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) begin
            n = $urandom_range(0, 15);
            keys[n] = ~keys[n];
         end
         pulse = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
         reset = ($urandom_range(0, 399) == 0);
      end
      reset = 1'b0;
      pulse = 4'h0;
      keys  = '0;
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
